// File: rtl/spart_host.sv
// rtl/spart_host.sv - host-side sequencer for a SPART serial port register interface
//
// Purpose:
//   After reset, programs the SPART baud divisor with two register writes.
//   It then moves bytes between a valid/ready transmit stream and the SPART
//   data register, and between the SPART data register and a valid/ready
//   receive stream. While nothing else is pending, it periodically reads the
//   SPART status register.
//   Every bus access lasts exactly one cycle and is followed by one GAP cycle.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   iocs_n          SPART chip select (active low)
//   iorw_n          1 = read, 0 = write
//   ioaddr          00 data, 01 status, 10 DBL, 11 DBH
//   databus         bidirectional SPART data bus, driven only on writes
//   tx_q_full       SPART transmit queue full
//   rx_q_empty      SPART receive queue empty
//   tx_data/valid/ready  transmit byte stream into the SPART
//   rx_data/valid/ready  receive byte stream out of the SPART
//   cfg_done        baud divisor has been written
//   tx_space/rx_count    status nibbles from the last status read

module spart_host #(
  parameter logic [12:0] BAUD_DIV    = 13'h01B2,
  parameter logic [7:0]  STAT_PERIOD = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       iocs_n,
  output logic       iorw_n,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       tx_q_full,
  input  logic       rx_q_empty,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       cfg_done,
  output logic [3:0] tx_space,
  output logic [3:0] rx_count
);

  typedef enum logic [2:0] {
    CFG_LO = 3'd0,
    CFG_HI = 3'd1,
    IDLE   = 3'd2,
    TX_WR  = 3'd3,
    RX_RD  = 3'd4,
    ST_RD  = 3'd5,
    GAP    = 3'd6
  } state_t;

  state_t     state;
  // started holds CFG_LO inactive while reset is asserted. The DBL write
  // therefore occupies the first full cycle after release.
  logic       started;
  logic       cfg_hi_done;
  // last_rx records which side won the previous data access. It starts at 0,
  // so RX wins the first tie after reset.
  logic       last_rx;
  logic [7:0] idle_cnt;
  logic [7:0] wr_data;
  logic       rx_elig;
  logic       tx_elig;

  assign rx_elig = !rx_q_empty && !rx_valid;
  assign tx_elig = tx_valid && !tx_q_full;

  // Bus controls are a pure decode of the state register. Reset clears
  // started asynchronously, so the bus goes idle immediately.
  always_comb begin
    iocs_n   = 1'b1;
    iorw_n   = 1'b1;
    ioaddr   = 2'b00;
    tx_ready = 1'b0;
    wr_data  = 8'h00;
    case (state)
      CFG_LO: begin
        if (started) begin
          iocs_n  = 1'b0;
          iorw_n  = 1'b0;
          ioaddr  = 2'b10;
          wr_data = BAUD_DIV[7:0];
        end
      end
      CFG_HI: begin
        iocs_n  = 1'b0;
        iorw_n  = 1'b0;
        ioaddr  = 2'b11;
        wr_data = {3'b000, BAUD_DIV[12:8]};
      end
      TX_WR: begin
        iocs_n   = 1'b0;
        iorw_n   = 1'b0;
        ioaddr   = 2'b00;
        wr_data  = tx_data;
        tx_ready = 1'b1;
      end
      RX_RD: begin
        iocs_n = 1'b0;
        iorw_n = 1'b1;
        ioaddr = 2'b00;
      end
      ST_RD: begin
        iocs_n = 1'b0;
        iorw_n = 1'b1;
        ioaddr = 2'b01;
      end
      default: begin
        iocs_n = 1'b1;
      end
    endcase
  end

  assign databus = (!iocs_n && !iorw_n) ? wr_data : 8'hzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CFG_LO;
      started     <= 1'b0;
      cfg_hi_done <= 1'b0;
      cfg_done    <= 1'b0;
      last_rx     <= 1'b0;
      idle_cnt    <= 8'h00;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_space    <= 4'h0;
      rx_count    <= 4'h0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        CFG_LO: begin
          if (!started) begin
            started <= 1'b1;
          end else begin
            state <= GAP;
          end
        end
        CFG_HI: begin
          cfg_hi_done <= 1'b1;
          state       <= GAP;
        end
        GAP: begin
          if (cfg_done) begin
            state <= IDLE;
          end else if (cfg_hi_done) begin
            state    <= IDLE;
            cfg_done <= 1'b1;
          end else begin
            state <= CFG_HI;
          end
        end
        IDLE: begin
          // When both sides are eligible, they take turns.
          if (rx_elig && (!tx_elig || !last_rx)) begin
            state    <= RX_RD;
            last_rx  <= 1'b1;
            idle_cnt <= 8'h00;
          end else if (tx_elig) begin
            state    <= TX_WR;
            last_rx  <= 1'b0;
            idle_cnt <= 8'h00;
          end else if (idle_cnt == STAT_PERIOD) begin
            state    <= ST_RD;
            idle_cnt <= 8'h00;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        TX_WR: begin
          state <= GAP;
        end
        RX_RD: begin
          rx_data  <= databus;
          rx_valid <= 1'b1;
          state    <= GAP;
        end
        ST_RD: begin
          tx_space <= databus[7:4];
          rx_count <= databus[3:0];
          state    <= GAP;
        end
        default: begin
          state <= CFG_LO;
        end
      endcase
    end
  end

endmodule
